vx_raster_dcr_queue: RTL and testbench

Multi-context device-configuration register block for the raster unit. Host DCR writes accumulate in a shadow `raster_dcrs_t`. A write to `DCR_RASTER_COMMIT` snapshots the shadow into a FIFO of up to `NUM_CTX` committed configurations. The raster front-end pops one configuration per draw through a valid/ready handshake, so the host can program draw N+1 while draw N is still rasterising.

---
 rtl/vx_raster_dcr_queue_pkg.sv | 49 ++++
 rtl/vx_raster_dcr_queue_fifo.sv | 50 +++++
 rtl/vx_raster_dcr_queue.sv | 118 +++++++++++
 tb/tb_vx_raster_dcr_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vx_raster_dcr_queue_pkg.sv
// Raster DCR address map, configuration record and shadow reset value
// shared by the raster DCR queue and its storage.
package vx_raster_dcr_queue_pkg;

  localparam int DCR_ADDR_BITS        = 12;
  localparam int RASTER_DCR_DATA_BITS = 32;
  localparam int RASTER_TILE_BITS     = 16;
  localparam int RASTER_STRIDE_BITS   = 16;
  localparam int RASTER_DIM_BITS      = 12;

  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_TBUF_ADDR   = 12'h010;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_TILE_COUNT  = 12'h011;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_PBUF_ADDR   = 12'h012;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_PBUF_STRIDE = 12'h013;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_SCISSOR_X   = 12'h014;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_SCISSOR_Y   = 12'h015;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_COMMIT      = 12'h016;
  localparam logic [DCR_ADDR_BITS-1:0] DCR_RASTER_STATUS      = 12'h017;

  typedef struct packed {
    logic [RASTER_DCR_DATA_BITS-1:0] tbuf_addr;
    logic [RASTER_DCR_DATA_BITS-1:0] pbuf_addr;
    logic [RASTER_TILE_BITS-1:0]     tile_count;
    logic [RASTER_STRIDE_BITS-1:0]   pbuf_stride;
    logic [RASTER_DIM_BITS-1:0]      dst_xmin;
    logic [RASTER_DIM_BITS-1:0]      dst_xmax;
    logic [RASTER_DIM_BITS-1:0]      dst_ymin;
    logic [RASTER_DIM_BITS-1:0]      dst_ymax;
  } raster_dcrs_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  // Scissor max fields reset to all-ones so an unprogrammed scissor clips nothing.
  localparam raster_dcrs_t RASTER_DCR_RESET = '{
    tbuf_addr:   {RASTER_DCR_DATA_BITS{1'b0}},
    pbuf_addr:   {RASTER_DCR_DATA_BITS{1'b0}},
    tile_count:  {RASTER_TILE_BITS{1'b0}},
    pbuf_stride: {RASTER_STRIDE_BITS{1'b0}},
    dst_xmin:    {RASTER_DIM_BITS{1'b0}},
    dst_xmax:    {RASTER_DIM_BITS{1'b1}},
    dst_ymin:    {RASTER_DIM_BITS{1'b0}},
    dst_ymax:    {RASTER_DIM_BITS{1'b1}}
  };

endpackage

// File: rtl/vx_raster_dcr_queue_fifo.sv
// Pointer-based storage for committed configurations; occupancy is tracked
// by the caller, which never pushes when full or pops when empty.
module vx_raster_dcr_queue_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}} : wr_ptr_q + {{(PTRW-1){1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}} : rd_ptr_q + {{(PTRW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTRW{1'b0}};
      rd_ptr_q <= {PTRW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = mem_q[rd_ptr_q];

endmodule

// File: rtl/vx_raster_dcr_queue.sv
// Raster DCR shadow plus a queue of committed configurations so the host can
// program draw N+1 while draw N is consumed by the raster front-end.
module vx_raster_dcr_queue
  import vx_raster_dcr_queue_pkg::*;
#(
  parameter int NUM_CTX = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dcr_write_valid,
  input  logic [DCR_ADDR_BITS-1:0]        dcr_write_addr,
  input  logic [31:0]                     dcr_write_data,
  output logic                            cfg_valid,
  output raster_dcrs_t                    cfg_dcrs,
  input  logic                            cfg_ready,
  output logic [$clog2(NUM_CTX+1)-1:0]    cfg_count,
  output logic                            overflow
);

  localparam int CNTW = $clog2(NUM_CTX + 1);

  raster_dcrs_t  shadow_q, shadow_d;
  logic [CNTW-1:0] count_q, count_d;
  occ_state_e    occ_q, occ_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic          commit, status_wr, push, pop, drop;

  always_comb begin
    shadow_d  = shadow_q;
    commit    = 1'b0;
    status_wr = 1'b0;
    if (dcr_write_valid) begin
      case (dcr_write_addr)
        DCR_RASTER_TBUF_ADDR:   shadow_d.tbuf_addr   = dcr_write_data[RASTER_DCR_DATA_BITS-1:0];
        DCR_RASTER_PBUF_ADDR:   shadow_d.pbuf_addr   = dcr_write_data[RASTER_DCR_DATA_BITS-1:0];
        DCR_RASTER_TILE_COUNT:  shadow_d.tile_count  = dcr_write_data[RASTER_TILE_BITS-1:0];
        DCR_RASTER_PBUF_STRIDE: shadow_d.pbuf_stride = dcr_write_data[RASTER_STRIDE_BITS-1:0];
        DCR_RASTER_SCISSOR_X: begin
          shadow_d.dst_xmin = dcr_write_data[0 +: RASTER_DIM_BITS];
          shadow_d.dst_xmax = dcr_write_data[16 +: RASTER_DIM_BITS];
        end
        DCR_RASTER_SCISSOR_Y: begin
          shadow_d.dst_ymin = dcr_write_data[0 +: RASTER_DIM_BITS];
          shadow_d.dst_ymax = dcr_write_data[16 +: RASTER_DIM_BITS];
        end
        DCR_RASTER_COMMIT: commit    = 1'b1;
        DCR_RASTER_STATUS: status_wr = 1'b1;
        default: ;
      endcase
    end
  end

  // A pop frees the slot in the same cycle, so a commit into a full queue
  // still succeeds when the consumer is draining.
  always_comb begin
    pop  = valid_q && cfg_ready;
    push = commit && ((occ_q != OCC_FULL) || pop);
    drop = commit && (occ_q == OCC_FULL) && !pop;

    case ({push, pop})
      2'b10:   count_d = count_q + {{(CNTW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNTW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    if (count_d == {CNTW{1'b0}}) begin
      occ_d = OCC_EMPTY;
    end else if (count_d == CNTW'(NUM_CTX)) begin
      occ_d = OCC_FULL;
    end else begin
      occ_d = OCC_PARTIAL;
    end

    valid_d = (count_d != {CNTW{1'b0}});

    if (status_wr) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= RASTER_DCR_RESET;
      count_q    <= {CNTW{1'b0}};
      occ_q      <= OCC_EMPTY;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      count_q    <= count_d;
      occ_q      <= occ_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  vx_raster_dcr_queue_fifo #(
    .DATAW ($bits(raster_dcrs_t)),
    .DEPTH (NUM_CTX)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (shadow_q),
    .data_out (cfg_dcrs)
  );

  assign cfg_valid = valid_q;
  assign cfg_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vx_raster_dcr_queue.sv
// Table-driven bench with a configuration scoreboard for vx_raster_dcr_queue.
module tb_vx_raster_dcr_queue;
  import vx_raster_dcr_queue_pkg::*;

  localparam int NUM_CTX = 2;

  logic         clk;
  logic         reset;
  logic         dcr_write_valid;
  logic [11:0]  dcr_write_addr;
  logic [31:0]  dcr_write_data;
  logic         cfg_valid;
  raster_dcrs_t cfg_dcrs;
  logic         cfg_ready;
  logic [1:0]   cfg_count;
  logic         overflow;

  vx_raster_dcr_queue #(.NUM_CTX(NUM_CTX)) dut (
    .clk             (clk),
    .reset           (reset),
    .dcr_write_valid (dcr_write_valid),
    .dcr_write_addr  (dcr_write_addr),
    .dcr_write_data  (dcr_write_data),
    .cfg_valid       (cfg_valid),
    .cfg_dcrs        (cfg_dcrs),
    .cfg_ready       (cfg_ready),
    .cfg_count       (cfg_count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        exp_valid;
    logic [1:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  raster_dcrs_t sb_q[$];
  raster_dcrs_t m_shadow;
  raster_dcrs_t rst_val;
  int           m_count;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic raster_dcrs_t decode(input raster_dcrs_t s, input logic [11:0] a, input logic [31:0] d);
    raster_dcrs_t r;
    r = s;
    if (a == DCR_RASTER_TBUF_ADDR)   r.tbuf_addr   = d;
    if (a == DCR_RASTER_PBUF_ADDR)   r.pbuf_addr   = d;
    if (a == DCR_RASTER_TILE_COUNT)  r.tile_count  = d[15:0];
    if (a == DCR_RASTER_PBUF_STRIDE) r.pbuf_stride = d[15:0];
    if (a == DCR_RASTER_SCISSOR_X) begin r.dst_xmin = d[11:0]; r.dst_xmax = d[27:16]; end
    if (a == DCR_RASTER_SCISSOR_Y) begin r.dst_ymin = d[11:0]; r.dst_ymax = d[27:16]; end
    return r;
  endfunction

  // One cycle: score any pop, model any commit, then clock and settle.
  task automatic apply(input logic wv, input logic [11:0] addr, input logic [31:0] data, input logic rdy);
    logic pop;
    raster_dcrs_t e;
    dcr_write_valid = wv;
    dcr_write_addr  = addr;
    dcr_write_data  = data;
    cfg_ready       = rdy;
    #1;
    pop = cfg_valid && rdy;
    if (pop) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL pop_unexpected: got pop with data %0h expected no entry", cfg_dcrs);
      end else begin
        e = sb_q.pop_front();
        check("pop_data", 160'(cfg_dcrs), 160'(e));
      end
      m_count--;
    end
    if (wv && addr == DCR_RASTER_COMMIT && (m_count < NUM_CTX)) begin
      sb_q.push_back(m_shadow);
      m_count++;
    end
    if (wv) m_shadow = decode(m_shadow, addr, data);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[22];

  initial begin
    rst_val = RASTER_DCR_RESET;
    rst_val.dst_xmin = 12'h000;
    vecs[0]  = '{1'b1, DCR_RASTER_TBUF_ADDR,   32'h0000_1000, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, DCR_RASTER_TILE_COUNT,  32'h0000_0004, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, DCR_RASTER_COMMIT,      32'hFFFF_FFFF, 1'b0, 1'b1, 2'd1, 1'b0};
    vecs[3]  = '{1'b0, 12'h000,                32'h0000_0000, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, DCR_RASTER_TBUF_ADDR,   32'h0000_0010, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, DCR_RASTER_COMMIT,      32'h0000_0000, 1'b0, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{1'b1, DCR_RASTER_TBUF_ADDR,   32'h0000_0020, 1'b0, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, DCR_RASTER_COMMIT,      32'h0000_0000, 1'b0, 1'b1, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, DCR_RASTER_COMMIT,      32'h0000_0000, 1'b0, 1'b1, 2'd2, 1'b1};
    vecs[9]  = '{1'b0, 12'h000,                32'h0000_0000, 1'b0, 1'b1, 2'd2, 1'b1};
    vecs[10] = '{1'b1, DCR_RASTER_STATUS,      32'h0000_0000, 1'b0, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{1'b1, DCR_RASTER_SCISSOR_X,   32'h00FF_0010, 1'b1, 1'b1, 2'd1, 1'b0};
    vecs[12] = '{1'b1, DCR_RASTER_COMMIT,      32'h0000_0000, 1'b0, 1'b1, 2'd2, 1'b0};
    vecs[13] = '{1'b1, DCR_RASTER_COMMIT,      32'h0000_0000, 1'b1, 1'b1, 2'd2, 1'b0};
    vecs[14] = '{1'b0, 12'h000,                32'h0000_0000, 1'b1, 1'b1, 2'd1, 1'b0};
    vecs[15] = '{1'b0, 12'h000,                32'h0000_0000, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 12'h000,                32'h0000_0000, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{1'b1, DCR_RASTER_SCISSOR_Y,   32'h0ABC_0123, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[18] = '{1'b1, 12'h0FF,                32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[19] = '{1'b1, DCR_RASTER_PBUF_ADDR,   32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[20] = '{1'b1, DCR_RASTER_PBUF_STRIDE, 32'h1234_5678, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[21] = '{1'b1, DCR_RASTER_COMMIT,      32'h0000_0000, 1'b1, 1'b1, 2'd1, 1'b0};

    dcr_write_valid = 1'b0;
    dcr_write_addr  = 12'h000;
    dcr_write_data  = 32'h0;
    cfg_ready       = 1'b0;
    reset           = 1'b1;
    m_shadow        = RASTER_DCR_RESET;
    m_count         = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", 160'(cfg_valid), 160'(1'b0));
    check("rst_count", 160'(cfg_count), 160'(2'd0));
    check("rst_ovf",   160'(overflow),  160'(1'b0));

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].wv, vecs[i].addr, vecs[i].data, vecs[i].rdy);
      check($sformatf("v%0d_valid", i), 160'(cfg_valid), 160'(vecs[i].exp_valid));
      check($sformatf("v%0d_count", i), 160'(cfg_count), 160'(vecs[i].exp_count));
      check($sformatf("v%0d_ovf", i),   160'(overflow),  160'(vecs[i].exp_ovf));
    end
    apply(1'b0, 12'h000, 32'h0, 1'b1);
    check("drain_valid", 160'(cfg_valid), 160'(1'b0));

    // Hand-checked field values of the last committed configuration.
    check("hand_xmax_sb", 160'(m_shadow.dst_xmax), 160'(12'h0FF));
    check("hand_ymin_sb", 160'(m_shadow.dst_ymin), 160'(12'h123));
    check("hand_stride_sb", 160'(m_shadow.pbuf_stride), 160'(16'h5678));

    // Reset with two entries queued and a commit in the reset cycle.
    apply(1'b1, DCR_RASTER_COMMIT, 32'h0, 1'b0);
    apply(1'b1, DCR_RASTER_COMMIT, 32'h0, 1'b0);
    apply(1'b1, DCR_RASTER_COMMIT, 32'h0, 1'b0);
    check("pre_rst_count", 160'(cfg_count), 160'(2'd2));
    check("pre_rst_ovf",   160'(overflow),  160'(1'b1));
    reset = 1'b1;
    dcr_write_valid = 1'b1;
    dcr_write_addr  = DCR_RASTER_COMMIT;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dcr_write_valid = 1'b0;
    sb_q.delete();
    m_count  = 0;
    m_shadow = RASTER_DCR_RESET;
    check("mid_rst_valid", 160'(cfg_valid), 160'(1'b0));
    check("mid_rst_count", 160'(cfg_count), 160'(2'd0));
    check("mid_rst_ovf",   160'(overflow),  160'(1'b0));
    apply(1'b1, DCR_RASTER_COMMIT, 32'h0, 1'b0);
    check("post_rst_valid", 160'(cfg_valid), 160'(1'b1));
    check("post_rst_data",  160'(cfg_dcrs),  160'(rst_val));
    apply(1'b0, 12'h000, 32'h0, 1'b1);
    check("post_rst_empty", 160'(cfg_valid), 160'(1'b0));
    check("sb_empty", 160'(sb_q.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
